// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
//   Multi-cycle RV32M divide/remainder unit. It sits beside the single-cycle
//   ALU and returns O plus Z/N/C/V flags with ALU semantics. The pipeline
//   stalls while busy is high.
//   Radix-2 restoring division on operand magnitudes produces one quotient bit
//   per cycle. A final cycle applies the sign correction.
//   Divide-by-zero and signed overflow bypass the iteration and finish in one
//   cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only while idle
//   operation  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A, B       dividend / divisor, captured on the accepted start
//   kill       pipeline flush, abandons the operation in flight
//   busy       high whenever not idle
//   done       one-cycle pulse; O and flags are valid from this cycle on
//   O          result, held until the next result is produced
//   Z, N, C, V ALU-style flags: Z=(O==0), N=sign of O, C=0, V=DIV overflow
// -----------------------------------------------------------------------------
module iterative_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      operation,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] O,
    output logic            Z,
    output logic            N,
    output logic            C,
    output logic            V
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_reg, state_next;
    logic [5:0]      count_reg;
    logic [XLEN-1:0] rem_reg, quo_reg, div_reg;
    logic            is_rem_reg, neg_q_reg, neg_r_reg;
    logic [XLEN-1:0] o_reg;
    logic            z_reg, n_reg, v_reg;

    // Operand decode for the start cycle
    logic            is_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, ovf, fast;
    logic [XLEN-1:0] fast_o;
    logic            fast_v;
    logic            accept;

    assign is_signed = ~operation[0];
    assign a_neg     = is_signed & A[XLEN-1];
    assign b_neg     = is_signed & B[XLEN-1];
    assign a_mag     = a_neg ? (~A + 1'b1) : A;
    assign b_mag     = b_neg ? (~B + 1'b1) : B;
    assign div_zero  = (B == '0);
    // Most-negative / -1 is the only signed case whose quotient does not fit
    assign ovf       = is_signed & (A == {1'b1, {(XLEN-1){1'b0}}}) & (&B);
    assign fast      = div_zero | ovf;
    assign accept    = (state_reg == IDLE) & start & ~kill;

    always_comb begin
        fast_o = '0;
        fast_v = 1'b0;
        if (div_zero) begin
            fast_o = operation[1] ? A : '1;
        end else begin
            fast_o = operation[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            fast_v = ~operation[1];
        end
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor. The extra top bit of the trial is
    // the borrow, so a set MSB means the subtraction went negative.
    logic [XLEN:0]   rem_shift, trial;
    assign rem_shift = {rem_reg, quo_reg[XLEN-1]};
    assign trial     = rem_shift - {1'b0, div_reg};

    // Sign correction applied in FIX
    logic [XLEN-1:0] q_fix, r_fix, fix_o;
    assign q_fix = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
    assign r_fix = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;
    assign fix_o = is_rem_reg ? r_fix : q_fix;

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        done       = (state_reg == DONE);
        case (state_reg)
            IDLE: if (start && !kill) state_next = fast ? DONE : CALC;
            CALC: begin
                if (kill)                              state_next = IDLE;
                else if (count_reg == 6'(XLEN - 1))    state_next = FIX;
            end
            FIX:  state_next = kill ? IDLE : DONE;
            // A kill here is ignored because the result is already committed
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            rem_reg    <= '0;
            quo_reg    <= '0;
            div_reg    <= '0;
            is_rem_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            o_reg      <= '0;
            z_reg      <= 1'b0;
            n_reg      <= 1'b0;
            v_reg      <= 1'b0;
        end else begin
            if (accept) begin
                count_reg  <= '0;
                rem_reg    <= '0;
                quo_reg    <= a_mag;
                div_reg    <= b_mag;
                is_rem_reg <= operation[1];
                neg_q_reg  <= a_neg ^ b_neg;
                neg_r_reg  <= a_neg;
                if (fast) begin
                    o_reg <= fast_o;
                    z_reg <= (fast_o == '0);
                    n_reg <= fast_o[XLEN-1];
                    v_reg <= fast_v;
                end
            end else if (state_reg == CALC && !kill) begin
                rem_reg   <= trial[XLEN] ? rem_shift[XLEN-1:0] : trial[XLEN-1:0];
                quo_reg   <= {quo_reg[XLEN-2:0], ~trial[XLEN]};
                count_reg <= count_reg + 6'd1;
            end else if (state_reg == FIX && !kill) begin
                o_reg <= fix_o;
                z_reg <= (fix_o == '0);
                n_reg <= fix_o[XLEN-1];
                v_reg <= 1'b0;
            end
        end
    end

    assign O = o_reg;
    assign Z = z_reg;
    assign N = n_reg;
    assign C = 1'b0;
    assign V = v_reg;

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, kill;
    logic [1:0]  operation;
    logic [31:0] A, B;
    logic        busy, done, Z, N, C, V;
    logic [31:0] O;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] last_o = 32'h0;

    iterative_divider #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
        .A(A), .B(B), .kill(kill), .busy(busy), .done(done),
        .O(O), .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: plain RV32M arithmetic semantics
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] o, output logic v, output logic fast);
        int signed sa, sb;
        sa = a; sb = b;
        v = 1'b0; fast = 1'b0; o = 32'h0;
        if (b == 32'h0) begin
            fast = 1'b1;
            o = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            fast = 1'b1;
            o = op[1] ? 32'h0 : 32'h8000_0000;
            v = ~op[1];
        end else begin
            case (op)
                2'd0: o = sa / sb;
                2'd1: o = a / b;
                2'd2: o = sa % sb;
                default: o = a % b;
            endcase
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_O"}, O, 32'h0);
        check({tag, "_flags"}, {28'h0, Z, N, C, V}, 32'h0);
    endtask

    // Issue one operation. Optional disturbances at a given cycle
    // (start cycle = 0): spurious start, kill, or asynchronous reset. -1 = none.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int spur_cyc, input int kill_cyc, input int rst_cyc);
        logic [31:0] exp_o;
        logic        exp_v, fast;
        int          cyc, lat;
        bit          busy_ok, saw_done;
        model(op, a, b, exp_o, exp_v, fast);
        lat = fast ? 1 : 34;
        @(negedge clk);
        start = 1'b1; operation = op; A = a; B = b;
        @(negedge clk);
        start = 1'b0; operation = 2'($urandom); A = $urandom; B = $urandom;
        cyc = 1;
        busy_ok = 1'b1;
        while (cyc < 60) begin
            if (done) break;
            if (!busy) busy_ok = 1'b0;
            if (cyc == kill_cyc) begin
                kill = 1'b1;
                @(negedge clk);
                kill = 1'b0;
                check("kill_busy", {31'h0, busy}, 32'h0);
                check("kill_done", {31'h0, done}, 32'h0);
                check("kill_O_kept", O, last_o);
                saw_done = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (done) saw_done = 1'b1;
                end
                check("kill_no_done", {31'h0, saw_done}, 32'h0);
                $display("op=%0d A=%h B=%h killed at cycle %0d", op, a, b, kill_cyc);
                return;
            end
            if (cyc == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("midrst");
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                last_o = 32'h0;
                $display("op=%0d A=%h B=%h reset at cycle %0d", op, a, b, rst_cyc);
                return;
            end
            start = (cyc == spur_cyc);
            if (start) begin
                operation = 2'($urandom); A = $urandom; B = $urandom_range(9, 1);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", cyc, lat);
        check("busy_during", {31'h0, busy_ok & busy}, 32'h1);
        check("O", O, exp_o);
        check("flags", {28'h0, Z, N, C, V}, {28'h0, exp_o == 32'h0, exp_o[31], 1'b0, exp_v});
        $display("op=%0d A=%h B=%h O=%h exp=%h lat=%0d", op, a, b, O, exp_o, cyc);
        @(negedge clk);
        check("done_pulse", {30'h0, done, busy}, 32'h0);
        check("O_held", O, exp_o);
        last_o = exp_o;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; operation = 2'd0; A = 32'h0; B = 32'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        run_op(2'd0, 32'd100, 32'd7, -1, -1, -1);
        run_op(2'd2, 32'd100, 32'd7, -1, -1, -1);
        run_op(2'd0, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
        run_op(2'd1, 32'hFFFF_FFFF, 32'd1, -1, -1, -1);
        run_op(2'd3, 32'd5, 32'd5, -1, -1, -1);
        run_op(2'd1, 32'd9, 32'd0, -1, -1, -1);
        run_op(2'd2, 32'd9, 32'd0, -1, -1, -1);
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
        run_op(2'd0, 32'd1000, 32'hFFFF_FFFD, -1, -1, -1);
        // Spurious start while busy must be ignored
        run_op(2'd0, 32'd100, 32'd7, 5, -1, -1);
        // Kill in CALC, then a clean operation
        run_op(2'd0, 32'd12345, 32'd3, -1, 10, -1);
        run_op(2'd3, 32'd100, 32'd7, -1, -1, -1);

        // start and kill together in IDLE: start dropped
        @(negedge clk);
        start = 1'b1; kill = 1'b1; operation = 2'd0; A = 32'd50; B = 32'd5;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("startkill_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("startkill_done", {31'h0, done}, 32'h0);
        check("startkill_O", O, last_o);
        $display("start+kill in idle dropped, O=%h", O);

        // Reset mid-operation (O non-zero beforehand)
        run_op(2'd0, 32'd100, 32'd7, -1, -1, -1);
        run_op(2'd1, 32'd12345, 32'd7, -1, -1, 20);
        run_op(2'd1, 32'd12345, 32'd7, -1, -1, -1);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(15, 0))
                0, 1:    rb = 32'h0;
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3, 4, 5: rb = $urandom_range(17, 1);
                6:       rb = -$urandom_range(17, 1);
                default: rb = $urandom >> $urandom_range(31, 0);
            endcase
            run_op(rop, ra, rb, -1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
